// File: rtl/dual_lane_merge_pkg.sv
// Shared definitions for dual_lane_merge and its lane FIFO.
//   DATA_W_DEF      default lane / output data width
//   DEPTH_DEF       default per-lane FIFO depth (power of two, >= 2)
//   lane_t          lane index (0 or 1)
//   LAST_SERVED_RST reset value of the round-robin pointer; 1 makes lane 0
//                   win the first tie after reset
package dual_lane_merge_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  typedef logic lane_t;

  localparam lane_t LAST_SERVED_RST = 1'b1;
endpackage

// File: rtl/dual_lane_merge_lane_fifo.sv
// lane_fifo: synchronous FIFO, DEPTH words of DATA_W bits.
//   clk, rst  clock / synchronous active-high reset
//   push_i    write data_i this cycle (caller guarantees room or same-cycle pop)
//   data_i    write data
//   pop_i     discard the head word this cycle (caller guarantees non-empty)
//   data_o    head word (valid while empty_o=0)
//   full_o    count_o == DEPTH
//   empty_o   count_o == 0
//   count_o   occupancy 0..DEPTH
module lane_fifo import dual_lane_merge_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_i && !pop_i) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_i && pop_i) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/dual_lane_merge.sv
// dual_lane_merge: buffers two free-running producer lanes in per-lane FIFOs
// and merges them round-robin into one valid/ready stream tagged with the
// source lane. Words arriving on a full FIFO that is not popped are dropped
// and counted.
//   clk, rst              clock / synchronous active-high reset
//   valid0, data_bus0     lane 0 word strobe and data (no backpressure)
//   valid1, data_bus1     lane 1 word strobe and data (no backpressure)
//   out_valid, out_ready  output handshake
//   out_data, out_src     merged word and its source lane
//   overflow              sticky per-lane drop flags
//   drop_cnt0, drop_cnt1  saturating per-lane drop counters
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_data and
// out_src hold. out_valid does not depend on out_ready.
module dual_lane_merge import dual_lane_merge_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid0,
  input  logic [DATA_W-1:0] data_bus0,
  input  logic              valid1,
  input  logic [DATA_W-1:0] data_bus1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic [1:0]        overflow,
  output logic [CNT_W-1:0]  drop_cnt0,
  output logic [CNT_W-1:0]  drop_cnt1
);
  localparam int FCNT_W = $clog2(DEPTH) + 1;
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);

  logic [1:0]        in_valid;
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        full;
  logic [1:0]        empty;
  logic [1:0]        drop;
  logic [DATA_W-1:0] head [2];
  logic [FCNT_W-1:0] cnt  [2];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  lane_t             out_src_q,   out_src_d;
  lane_t             last_q,      last_d;
  logic [1:0]        overflow_q;
  logic [CNT_W-1:0]  drop_cnt_q [2];

  logic  load;
  logic  any_ne;
  lane_t sel;

  assign in_valid   = {valid1, valid0};
  assign in_data[0] = data_bus0;
  assign in_data[1] = data_bus1;

  for (genvar n = 0; n < 2; n++) begin : g_lane
    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[n]),
      .data_i  (in_data[n]),
      .pop_i   (pop[n]),
      .data_o  (head[n]),
      .full_o  (full[n]),
      .empty_o (empty[n]),
      .count_o (cnt[n])
    );
    // A full FIFO still accepts a word when its head leaves this cycle.
    assign push[n] = in_valid[n] & ((cnt[n] != FULL_CNT) | pop[n]);
    assign drop[n] = in_valid[n] & full[n] & ~pop[n];
  end

  // Arbitration sees FIFO contents only; this cycle's input words become
  // eligible next cycle.
  always_comb begin
    load        = ~out_valid_q | out_ready;
    any_ne      = ~(empty[0] & empty[1]);
    sel         = 1'b0;
    pop         = 2'b00;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;

    if (!empty[0] && !empty[1]) begin
      sel = ~last_q;
    end else if (!empty[0]) begin
      sel = 1'b0;
    end else begin
      sel = 1'b1;
    end

    if (load) begin
      if (any_ne) begin
        pop[sel]    = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = head[sel];
        out_src_d   = sel;
        last_d      = sel;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      last_q      <= LAST_SERVED_RST;
      overflow_q  <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        drop_cnt_q[n] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
      for (int n = 0; n < 2; n++) begin
        if (drop[n]) begin
          overflow_q[n] <= 1'b1;
          if (drop_cnt_q[n] != '1) begin
            drop_cnt_q[n] <= drop_cnt_q[n] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign overflow  = overflow_q;
  assign drop_cnt0 = drop_cnt_q[0];
  assign drop_cnt1 = drop_cnt_q[1];
endmodule

// File: tb/tb_dual_lane_merge.sv
// Bench for dual_lane_merge: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations. A second
// instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_dual_lane_merge;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          valid0, valid1;
  logic [DW-1:0] data_bus0, data_bus1;
  logic          out_ready;

  logic          out_valid, out_src;
  logic [DW-1:0] out_data;
  logic [1:0]    overflow;
  logic [7:0]    drop_cnt0, drop_cnt1;

  logic          s_out_valid, s_out_src;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_overflow;
  logic [1:0]    s_drop_cnt0, s_drop_cnt1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  dual_lane_merge #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .valid0(valid0), .data_bus0(data_bus0),
    .valid1(valid1), .data_bus1(data_bus1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src),
    .overflow(overflow), .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  dual_lane_merge #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .valid0(valid0), .data_bus0(data_bus0),
    .valid1(valid1), .data_bus1(data_bus1),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_src(s_out_src),
    .overflow(s_overflow), .drop_cnt0(s_drop_cnt0), .drop_cnt1(s_drop_cnt1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each lane is a plain queue of at most DEPTH words; the output slot is
  // refilled from the queues before this cycle's arrivals are appended.
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  bit            m_valid = 0;
  logic [DW-1:0] m_data  = '0;
  bit            m_src   = 0;
  bit            m_last  = 1;
  bit [1:0]      m_ovf   = 2'b00;
  int            m_dc0   = 0;
  int            m_dc1   = 0;

  always @(posedge clk) begin
    bit load;
    bit have;
    bit sel;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      m_valid = 0; m_data = '0; m_src = 0; m_last = 1;
      m_ovf = 2'b00; m_dc0 = 0; m_dc1 = 0;
    end else begin
      load = !m_valid || out_ready;
      have = 0;
      sel  = 0;
      if (load) begin
        if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
          sel = !m_last; have = 1;
        end else if (exp_q0.size() > 0) begin
          sel = 0; have = 1;
        end else if (exp_q1.size() > 0) begin
          sel = 1; have = 1;
        end
        if (have) begin
          if (sel) m_data = exp_q1.pop_front();
          else     m_data = exp_q0.pop_front();
          m_src = sel; m_last = sel; m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      if (valid0) begin
        if (exp_q0.size() < DEPTH) exp_q0.push_back(data_bus0);
        else begin m_dc0++; m_ovf[0] = 1; end
      end
      if (valid1) begin
        if (exp_q1.size() < DEPTH) exp_q1.push_back(data_bus1);
        else begin m_dc1++; m_ovf[1] = 1; end
      end
    end
  end

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("m_out_data", int'(out_data), int'(m_data));
        chk("m_out_src",  int'(out_src),  int'(m_src));
      end
      chk("m_overflow",  int'(overflow),  int'(m_ovf));
      chk("m_drop_cnt0", int'(drop_cnt0), sat(m_dc0, 255));
      chk("m_drop_cnt1", int'(drop_cnt1), sat(m_dc1, 255));
      chk("m_s_out_valid", int'(s_out_valid), int'(m_valid));
      chk("m_s_drop_cnt0", int'(s_drop_cnt0), sat(m_dc0, 3));
      chk("m_s_drop_cnt1", int'(s_drop_cnt1), sat(m_dc1, 3));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1);
    valid0 = v0; data_bus0 = d0;
    valid1 = v1; data_bus1 = d1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, '0, 0, '0);
    cyc();
    rst = 1'b0;
  endtask

  logic [DW-1:0] bp_in  [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9};
  logic [DW-1:0] bp_out [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
  logic [DW-1:0] fp_out [5] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h7};
  bit            rdy_pat [16] = '{1,0,1,1,0,0,1,0,1,1,1,0,1,0,0,1};

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(0, '0, 0, '0);
    cyc();
    chk_en = 1;
    cyc();
    rst = 1'b0;

    // reset state
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_out_src",   int'(out_src),   0);
    chk("rst_overflow",  int'(overflow),  0);
    chk("rst_drop_cnt0", int'(drop_cnt0), 0);
    chk("rst_drop_cnt1", int'(drop_cnt1), 0);

    // single word: visible two edges after it is sampled, for one cycle
    out_ready = 1'b1;
    drive(1, 4'hA, 0, '0);
    cyc();
    chk("single_not_yet", int'(out_valid), 0);
    drive(0, '0, 0, '0);
    cyc();
    chk("single_valid", int'(out_valid), 1);
    chk("single_data",  int'(out_data),  'hA);
    chk("single_src",   int'(out_src),   0);
    cyc();
    chk("single_gone",  int'(out_valid), 0);

    // backpressure on lane 1: first word goes to the output register,
    // next four fill the FIFO, the sixth is dropped
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, '0, 1, bp_in[i]);
      cyc();
    end
    drive(0, '0, 0, '0);
    cyc();
    chk("bp_overflow",  int'(overflow),  2);
    chk("bp_drop_cnt1", int'(drop_cnt1), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_seq_valid", int'(out_valid), 1);
      chk("bp_seq_data",  int'(out_data),  int'(bp_out[i]));
      chk("bp_seq_src",   int'(out_src),   1);
      cyc();
    end
    chk("bp_drained", int'(out_valid), 0);

    // full lane 0 popped and pushed in the same cycle: no drop
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1, DW'(i), 0, '0);
      cyc();
    end
    drive(0, '0, 0, '0);
    cyc();
    out_ready = 1'b1;
    drive(1, 4'h7, 0, '0);
    cyc();
    drive(0, '0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      chk("fp_seq_data", int'(out_data), int'(fp_out[i]));
      cyc();
    end
    chk("fp_no_drop",  int'(drop_cnt0), 0);
    chk("fp_overflow", int'(overflow),  0);

    // saturation: lane 0 drops 6 words
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(1, DW'(i), 0, '0);
      cyc();
    end
    drive(0, '0, 1, 4'hC);
    cyc();
    drive(0, '0, 1, 4'hD);
    cyc();
    drive(0, '0, 0, '0);
    chk("sat_small_cnt0", int'(s_drop_cnt0), 3);
    chk("sat_wide_cnt0",  int'(drop_cnt0),   6);
    chk("sat_overflow",   int'(overflow),    1);
    chk("mid_pre_valid",  int'(out_valid),   1);

    // reset mid-stream with inputs present during the reset cycle
    rst = 1'b1;
    drive(1, 4'hF, 1, 4'hE);
    cyc();
    rst = 1'b0;
    drive(0, '0, 0, '0);
    chk("mid_out_valid", int'(out_valid),   0);
    chk("mid_overflow",  int'(overflow),    0);
    chk("mid_cnt0",      int'(drop_cnt0),   0);
    chk("mid_small_cnt", int'(s_drop_cnt0), 0);
    cyc();
    chk("mid_ignored", int'(out_valid), 0);

    // first tie after reset goes to lane 0
    out_ready = 1'b1;
    drive(1, 4'h3, 1, 4'h5);
    cyc();
    drive(0, '0, 0, '0);
    cyc();
    chk("tie_first_data", int'(out_data), 3);
    chk("tie_first_src",  int'(out_src),  0);
    cyc();
    chk("tie_second_data", int'(out_data), 5);
    chk("tie_second_src",  int'(out_src),  1);
    cyc();
    chk("tie_drained", int'(out_valid), 0);

    // both lanes streaming: output alternates starting with lane 0
    for (int i = 0; i < 10; i++) begin
      drive(1, DW'(i), 1, DW'(15 - i));
      cyc();
      if (i >= 1) chk("alt_src", int'(out_src), (i - 1) % 2);
    end

    // irregular out_ready with continued traffic, model-checked
    for (int i = 0; i < 16; i++) begin
      out_ready = rdy_pat[i];
      drive(i[0], DW'(i), i[1], DW'(i + 3));
      cyc();
    end

    drive(0, '0, 0, '0);
    out_ready = 1'b1;
    repeat (12) cyc();
    chk("final_drained", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
